vga_sync: RTL and testbench

VGA_SYNC -- requirements
Module: vga_sync

---
 rtl/vga_sync.sv | 84 ++++++++
 tb/tb_vga_sync.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync.sv
// VGA timing generator: divides clk down to a pixel strobe, walks the pixel/line
// counters and produces registered active-low syncs aligned with the counts.
module vga_sync #(
    parameter int CLK_DIV = 2,
    parameter int H_DISP  = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_DISP  = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_MAX  = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISP);
    localparam logic [9:0] V_VIS    = 10'(V_DISP);
    localparam logic [9:0] HS_START = 10'(H_DISP + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISP + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_DISP + V_FP + V_SYNC - 1);

    logic [3:0] div_cnt;
    logic [9:0] x_next;
    logic [9:0] y_next;

    assign p_tick     = (div_cnt == DIV_MAX);
    assign video_on   = (pixel_x < H_VIS) && (pixel_y < V_VIS);
    assign frame_tick = p_tick && (pixel_x == H_MAX) && (pixel_y == V_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= 4'd0;
        end else if (div_cnt == DIV_MAX) begin
            div_cnt <= 4'd0;
        end else begin
            div_cnt <= div_cnt + 4'd1;
        end
    end

    always_comb begin
        x_next = pixel_x;
        y_next = pixel_y;
        if (p_tick) begin
            if (pixel_x == H_MAX) begin
                x_next = 10'd0;
                y_next = (pixel_y == V_MAX) ? 10'd0 : pixel_y + 10'd1;
            end else begin
                x_next = pixel_x + 10'd1;
            end
        end
    end

    // Syncs are decoded from the next counts so they change on the same edge as the counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_x <= 10'd0;
            pixel_y <= 10'd0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
        end else begin
            pixel_x <= x_next;
            pixel_y <= y_next;
            hsync   <= !((x_next >= HS_START) && (x_next <= HS_END));
            vsync   <= !((y_next >= VS_START) && (y_next <= VS_END));
        end
    end

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: one full-size instance for line timing and two
// shrunken-timing instances (CLK_DIV 2 and 1) so whole frames stay short.
module tb_vga_sync;

    // shrunken timing: 32 pixels x 20 lines, hsync x 20..25, vsync y 14..15
    localparam int SH_DISP = 16, SH_FP = 4, SH_SYNC = 6, SH_BP = 6;
    localparam int SV_DISP = 12, SV_FP = 2, SV_SYNC = 2, SV_BP = 4;
    localparam int SH_TOT  = 32;
    localparam int SV_TOT  = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    logic       a_hs, a_vs, a_von, a_pt, a_ft;
    logic [9:0] a_x, a_y;
    logic       s_hs, s_vs, s_von, s_pt, s_ft;
    logic [9:0] s_x, s_y;
    logic       o_hs, o_vs, o_von, o_pt, o_ft;
    logic [9:0] o_x, o_y;

    always #5 clk = ~clk;

    vga_sync dut_a (
        .clk(clk), .rst(rst), .hsync(a_hs), .vsync(a_vs), .video_on(a_von),
        .p_tick(a_pt), .pixel_x(a_x), .pixel_y(a_y), .frame_tick(a_ft)
    );

    vga_sync #(
        .CLK_DIV(2), .H_DISP(SH_DISP), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
        .V_DISP(SV_DISP), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP)
    ) dut_s (
        .clk(clk), .rst(rst), .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
        .p_tick(s_pt), .pixel_x(s_x), .pixel_y(s_y), .frame_tick(s_ft)
    );

    vga_sync #(
        .CLK_DIV(1), .H_DISP(SH_DISP), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
        .V_DISP(SV_DISP), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP)
    ) dut_o (
        .clk(clk), .rst(rst), .hsync(o_hs), .vsync(o_vs), .video_on(o_von),
        .p_tick(o_pt), .pixel_x(o_x), .pixel_y(o_y), .frame_tick(o_ft)
    );

    // one rising edge, then sample on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (a_x !== 10'd0 || a_y !== 10'd0) begin
            failures++;
            $display("FAIL reset_counts: x=%0d y=%0d expected 0 0", a_x, a_y);
        end
        checks++;
        if (a_hs !== 1'b1 || a_vs !== 1'b1) begin
            failures++;
            $display("FAIL reset_syncs: hsync=%b vsync=%b expected 1 1", a_hs, a_vs);
        end
        checks++;
        if (a_pt !== 1'b0 || a_ft !== 1'b0 || a_von !== 1'b1) begin
            failures++;
            $display("FAIL reset_derived: p_tick=%b frame_tick=%b video_on=%b expected 0 0 1",
                     a_pt, a_ft, a_von);
        end
        checks++;
        if (o_pt !== 1'b1) begin
            failures++;
            $display("FAIL reset_ptick_div1: p_tick=%b expected 1", o_pt);
        end
    endtask

    task automatic test_pixel_count();
        rst = 1'b0;
        step();
        checks++;
        if (a_x !== 10'd0 || a_pt !== 1'b1) begin
            failures++;
            $display("FAIL first_ptick: x=%0d p_tick=%b expected 0 1", a_x, a_pt);
        end
        step();
        checks++;
        if (a_x !== 10'd1 || a_pt !== 1'b0) begin
            failures++;
            $display("FAIL x_after_2clk: x=%0d p_tick=%b expected 1 0", a_x, a_pt);
        end
        repeat (1597) step();
        checks++;
        if (a_x !== 10'd799 || a_y !== 10'd0) begin
            failures++;
            $display("FAIL x_end_of_line: x=%0d y=%0d expected 799 0", a_x, a_y);
        end
        step();
        checks++;
        if (a_x !== 10'd0 || a_y !== 10'd1) begin
            failures++;
            $display("FAIL x_wrap: x=%0d y=%0d expected 0 1", a_x, a_y);
        end
    endtask

    // starts at x=0, y=1 right after a line wrap
    task automatic test_hsync_line();
        int hs_low = 0;
        int von_hi = 0;
        int bad = 0;
        logic exp_hs;
        for (int i = 0; i < 1600; i++) begin
            exp_hs = !(a_x >= 10'd656 && a_x <= 10'd751);
            if (a_hs !== exp_hs) bad++;
            if (a_hs === 1'b0) hs_low++;
            if (a_von === 1'b1) von_hi++;
            step();
        end
        checks++;
        if (hs_low != 192) begin
            failures++;
            $display("FAIL hsync_low_clks: got %0d expected 192", hs_low);
        end
        checks++;
        if (von_hi != 1280) begin
            failures++;
            $display("FAIL video_on_clks: got %0d expected 1280", von_hi);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hsync_alignment: %0d cycles disagree with pixel_x window 656..751", bad);
        end
    endtask

    task automatic wait_s_tick(input string name, input int limit);
        int n = 0;
        while (s_ft !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        checks++;
        if (s_ft !== 1'b1) begin
            failures++;
            $display("FAIL %s: frame_tick not seen within %0d clk", name, limit);
        end
    endtask

    task automatic test_frame();
        int ticks = 0, vs_low = 0, lines = 0, row_hits = 0, row_bad = 0, range_bad = 0;
        wait_s_tick("frame_tick_wait", 3000);
        checks++;
        if (s_x !== 10'd31 || s_y !== 10'd19 || s_pt !== 1'b1) begin
            failures++;
            $display("FAIL frame_tick_position: x=%0d y=%0d p_tick=%b expected 31 19 1",
                     s_x, s_y, s_pt);
        end
        for (int i = 0; i < SH_TOT * SV_TOT * 2; i++) begin
            step();
            if (i == 0) begin
                checks++;
                if (s_x !== 10'd0 || s_y !== 10'd0) begin
                    failures++;
                    $display("FAIL frame_wrap: x=%0d y=%0d expected 0 0", s_x, s_y);
                end
            end
            if (s_ft === 1'b1) ticks++;
            if (s_vs === 1'b0) vs_low++;
            if (s_pt === 1'b1 && s_x == 10'd31) lines++;
            if (s_x > 10'd31 || s_y > 10'd19) range_bad++;
            if (s_x == 10'd0 && s_y == 10'd13) begin
                row_hits++;
                if (s_von !== 1'b0 || s_hs !== 1'b1 || s_vs !== 1'b1) row_bad++;
            end
        end
        checks++;
        if (ticks != 1 || s_ft !== 1'b1) begin
            failures++;
            $display("FAIL frame_period: ticks=%0d last=%b expected 1 1", ticks, s_ft);
        end
        checks++;
        if (vs_low != 128) begin
            failures++;
            $display("FAIL vsync_low_clks: got %0d expected 128", vs_low);
        end
        checks++;
        if (lines != SV_TOT || range_bad != 0) begin
            failures++;
            $display("FAIL line_count: lines=%0d out_of_range=%0d expected 20 0", lines, range_bad);
        end
        checks++;
        if (row_hits != 2 || row_bad != 0) begin
            failures++;
            $display("FAIL row_visit: hits=%0d bad=%0d expected 2 0", row_hits, row_bad);
        end
    endtask

    task automatic test_clkdiv1();
        int n = 0, low = 0, ticks = 0;
        while (o_ft !== 1'b1 && n < 2000) begin
            step();
            n++;
        end
        checks++;
        if (o_ft !== 1'b1) begin
            failures++;
            $display("FAIL div1_tick_wait: frame_tick not seen, got %b", o_ft);
        end
        for (int i = 0; i < SH_TOT * SV_TOT; i++) begin
            step();
            if (o_pt !== 1'b1) low++;
            if (o_ft === 1'b1) ticks++;
            if (i == 1) begin
                checks++;
                if (o_x !== 10'd1) begin
                    failures++;
                    $display("FAIL div1_pixel_rate: x=%0d expected 1", o_x);
                end
            end
        end
        checks++;
        if (low != 0) begin
            failures++;
            $display("FAIL div1_ptick: %0d cycles with p_tick low expected 0", low);
        end
        checks++;
        if (ticks != 1 || o_ft !== 1'b1) begin
            failures++;
            $display("FAIL div1_frame_period: ticks=%0d last=%b expected 1 1", ticks, o_ft);
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        while (!(s_x == 10'd22 && s_y == 10'd14) && n < 3000) begin
            step();
            n++;
        end
        checks++;
        if (s_hs !== 1'b0 || s_vs !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_setup: hsync=%b vsync=%b x=%0d y=%0d expected 0 0 at 22 14",
                     s_hs, s_vs, s_x, s_y);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (s_hs !== 1'b1 || s_vs !== 1'b1 || s_x !== 10'd0 || s_y !== 10'd0) begin
            failures++;
            $display("FAIL async_reset: hsync=%b vsync=%b x=%0d y=%0d expected 1 1 0 0",
                     s_hs, s_vs, s_x, s_y);
        end
        step();
        rst = 1'b0;
        n = 0;
        while (s_ft !== 1'b1 && n < 3000) begin
            step();
            n++;
        end
        // tick is seen one clk before the edge that wraps the frame
        checks++;
        if (n + 1 != SH_TOT * SV_TOT * 2) begin
            failures++;
            $display("FAIL reset_to_frame_tick: wrap edge at %0d clk expected %0d",
                     n + 1, SH_TOT * SV_TOT * 2);
        end
    endtask

    initial begin
        test_reset();
        test_pixel_count();
        test_hsync_line();
        test_frame();
        test_clkdiv1();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
